// File: rtl/multicycle_main_control_if.sv
// rtl/multicycle_main_control_if.sv - control bundle between the main control FSM and the datapath
interface multicycle_main_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic [1:0] pc_source;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       reg_write;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       illegal_op;
   logic       bus_error;
   logic [3:0] state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
             alu_op, illegal_op, bus_error, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
             alu_op, illegal_op, bus_error, state
   );
endinterface

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multi-cycle main control FSM with memory watchdog
module multicycle_main_control #(
   parameter logic [5:0] OP_RTYPE    = 6'b000000,
   parameter logic [5:0] OP_LW       = 6'b100011,
   parameter logic [5:0] OP_SW       = 6'b101011,
   parameter logic [5:0] OP_BNE      = 6'b000101,
   parameter logic [5:0] OP_XORI     = 6'b001110,
   parameter int         MEM_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   multicycle_main_control_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_I_EXEC    = 4'd9,
      S_I_WB      = 4'd10,
      S_ERROR     = 4'd15
   } state_t;

   // fetch flags the one state whose ir_write/pc_write follow mem_ready
   typedef struct packed {
      logic       fetch;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctl_t;

   localparam bit          WD_EN   = (MEM_TIMEOUT != 0);
   localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      state_q, state_nxt;
   ctl_t        ctl_q;
   logic [15:0] wait_cnt;
   logic        illegal_q, bus_err_q;
   logic        watched, timeout, set_illegal, set_bus_err;

   // Moore output decode; anything not named for a state stays 0
   function automatic ctl_t decode_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH:     begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
         S_DECODE:    c.alu_src_b = 2'b11;
         S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
         S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         S_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
         S_R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         S_BRANCH:    begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         S_I_EXEC:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
         S_I_WB:      c.reg_write = 1'b1;
         default:     ;
      endcase
      return c;
   endfunction

   // next-state selection; a ready memory always beats the watchdog
   always_comb begin
      state_nxt   = state_q;
      set_illegal = 1'b0;
      set_bus_err = 1'b0;
      watched     = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
      timeout     = WD_EN && watched && !bus.mem_ready && (wait_cnt == TO_LAST);
      case (state_q)
         S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
            if (bus.mem_ready) begin
               case (state_q)
                  S_FETCH:    state_nxt = S_DECODE;
                  S_MEM_READ: state_nxt = S_MEM_WB;
                  default:    state_nxt = S_FETCH;
               endcase
            end else if (timeout) begin
               state_nxt   = S_ERROR;
               set_bus_err = 1'b1;
            end
         end
         S_DECODE: begin
            if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_nxt = S_MEM_ADDR;
            else if (bus.opcode == OP_RTYPE)                 state_nxt = S_R_EXEC;
            else if (bus.opcode == OP_BNE)                   state_nxt = S_BRANCH;
            else if (bus.opcode == OP_XORI)                  state_nxt = S_I_EXEC;
            else begin
               state_nxt   = S_ERROR;
               set_illegal = 1'b1;
            end
         end
         // IR is stable here, so anything other than LW/SW means the decode was corrupted
         S_MEM_ADDR: begin
            if (bus.opcode == OP_LW)      state_nxt = S_MEM_READ;
            else if (bus.opcode == OP_SW) state_nxt = S_MEM_WRITE;
            else begin
               state_nxt   = S_ERROR;
               set_illegal = 1'b1;
            end
         end
         S_MEM_WB, S_R_WB, S_BRANCH, S_I_WB: state_nxt = S_FETCH;
         S_R_EXEC:                           state_nxt = S_R_WB;
         S_I_EXEC:                           state_nxt = S_I_WB;
         S_ERROR:                            state_nxt = S_ERROR;
         default:                            state_nxt = S_ERROR;
      endcase
   end

   // state, registered outputs, sticky flags and saturating wait counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         ctl_q     <= decode_ctl(S_FETCH);
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         ctl_q   <= decode_ctl(state_nxt);
         if (set_illegal) illegal_q <= 1'b1;
         if (set_bus_err) bus_err_q <= 1'b1;
         if (!watched || bus.mem_ready || (state_nxt != state_q)) wait_cnt <= '0;
         else if (wait_cnt != 16'hFFFF)                         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   assign bus.pc_write      = ctl_q.fetch & bus.mem_ready;
   assign bus.ir_write      = ctl_q.fetch & bus.mem_ready;
   assign bus.pc_write_cond = ctl_q.pc_write_cond;
   assign bus.pc_source     = ctl_q.pc_source;
   assign bus.i_or_d        = ctl_q.i_or_d;
   assign bus.mem_read      = ctl_q.mem_read;
   assign bus.mem_write     = ctl_q.mem_write;
   assign bus.reg_dst       = ctl_q.reg_dst;
   assign bus.reg_write     = ctl_q.reg_write;
   assign bus.mem_to_reg    = ctl_q.mem_to_reg;
   assign bus.alu_src_a     = ctl_q.alu_src_a;
   assign bus.alu_src_b     = ctl_q.alu_src_b;
   assign bus.alu_op        = ctl_q.alu_op;
   assign bus.illegal_op    = illegal_q;
   assign bus.bus_error     = bus_err_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - directed self-checking bench for multicycle_main_control
module tb_multicycle_main_control;
   logic clk;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   multicycle_main_control_if bus();

   multicycle_main_control dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // leaves the bench 2 time units after an edge, FETCH, with no edge yet seen out of reset
   task automatic apply_reset;
      reset_n = 1'b0;
      #3;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      bus.opcode    = 6'd0;
      bus.mem_ready = 1'b0;
      reset_n       = 1'b0;
      #23;
      n_checks++; if (bus.state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.state); end
      n_checks++; if (bus.illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %0b exp 0", bus.illegal_op); end
      n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_bus_error got %0b exp 0", bus.bus_error); end
      n_checks++; if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL reset_mem_read got %0b exp 1", bus.mem_read); end
      n_checks++; if (bus.alu_src_b !== 2'b01) begin n_fail++; $display("FAIL reset_alu_src_b got %0d exp 1", bus.alu_src_b); end
      n_checks++; if (bus.ir_write !== 1'b0) begin n_fail++; $display("FAIL reset_ir_write_lo got %0b exp 0", bus.ir_write); end
      bus.mem_ready = 1'b1;
      #1;
      n_checks++; if (bus.ir_write !== 1'b1) begin n_fail++; $display("FAIL reset_ir_write_hi got %0b exp 1", bus.ir_write); end
      n_checks++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write_hi got %0b exp 1", bus.pc_write); end
      apply_reset();
   endtask

   task automatic test_rtype;
      logic [3:0] exp_st [5];
      exp_st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      bus.opcode    = 6'b000000;
      bus.mem_ready = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (bus.state !== exp_st[i]) begin n_fail++; $display("FAIL rtype_state[%0d] got %0d exp %0d", i, bus.state, exp_st[i]); end
         n_checks++; if (bus.reg_write !== (exp_st[i] == 4'd7)) begin n_fail++; $display("FAIL rtype_reg_write[%0d] got %0b", i, bus.reg_write); end
         n_checks++; if (bus.reg_dst !== (exp_st[i] == 4'd7)) begin n_fail++; $display("FAIL rtype_reg_dst[%0d] got %0b", i, bus.reg_dst); end
         if (exp_st[i] == 4'd6) begin
            n_checks++; if (bus.alu_op !== 2'b10) begin n_fail++; $display("FAIL rtype_alu_op got %0d exp 2", bus.alu_op); end
         end
         if (i < 4) tick();
      end
   endtask

   task automatic test_lw_wait;
      logic [3:0] exp_st [9];
      bit         rdy    [9];
      exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
      rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      bus.opcode = 6'b100011;
      for (int i = 0; i < 9; i++) begin
         bus.mem_ready = rdy[i];
         #1;
         n_checks++; if (bus.state !== exp_st[i]) begin n_fail++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, bus.state, exp_st[i]); end
         if (exp_st[i] == 4'd3) begin
            n_checks++; if ({bus.mem_read, bus.i_or_d, bus.ir_write} !== 3'b110) begin n_fail++; $display("FAIL lw_mem_read[%0d] got %b exp 110", i, {bus.mem_read, bus.i_or_d, bus.ir_write}); end
         end
         if (exp_st[i] == 4'd4) begin
            n_checks++; if ({bus.reg_write, bus.mem_to_reg, bus.reg_dst} !== 3'b110) begin n_fail++; $display("FAIL lw_mem_wb got %b exp 110", {bus.reg_write, bus.mem_to_reg, bus.reg_dst}); end
         end
         if (i < 8) tick();
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp_st [12];
      logic [5:0] opc    [12];
      int         mw_cycles;
      exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
      opc    = '{6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b000101, 6'b000101,
                 6'b000101, 6'b001110, 6'b001110, 6'b001110, 6'b001110, 6'b001110};
      mw_cycles     = 0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus.opcode = opc[i];
         #1;
         n_checks++; if (bus.state !== exp_st[i]) begin n_fail++; $display("FAIL b2b_state[%0d] got %0d exp %0d", i, bus.state, exp_st[i]); end
         n_checks++; if (bus.pc_write_cond !== (exp_st[i] == 4'd8)) begin n_fail++; $display("FAIL b2b_pc_write_cond[%0d] got %0b", i, bus.pc_write_cond); end
         if (bus.mem_write === 1'b1) mw_cycles++;
         if (exp_st[i] == 4'd8) begin
            n_checks++; if ({bus.alu_op, bus.pc_source} !== 4'b0101) begin n_fail++; $display("FAIL b2b_bne got %b exp 0101", {bus.alu_op, bus.pc_source}); end
         end
         if (exp_st[i] == 4'd9) begin
            n_checks++; if ({bus.alu_op, bus.alu_src_b, bus.alu_src_a} !== 5'b11101) begin n_fail++; $display("FAIL b2b_xori_exec got %b exp 11101", {bus.alu_op, bus.alu_src_b, bus.alu_src_a}); end
         end
         if (exp_st[i] == 4'd10) begin
            n_checks++; if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b100) begin n_fail++; $display("FAIL b2b_xori_wb got %b exp 100", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); end
         end
         if (i < 11) tick();
      end
      n_checks++; if (mw_cycles !== 1) begin n_fail++; $display("FAIL b2b_sw_mem_write_cycles got %0d exp 1", mw_cycles); end
   endtask

   task automatic test_illegal;
      bus.opcode    = 6'b111111;
      bus.mem_ready = 1'b1;
      tick();
      n_checks++; if (bus.state !== 4'd1) begin n_fail++; $display("FAIL ill_decode got %0d exp 1", bus.state); end
      tick();
      n_checks++; if (bus.illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_flag got %0b exp 1", bus.illegal_op); end
      n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL ill_bus_error got %0b exp 0", bus.bus_error); end
      for (int i = 0; i < 20; i++) begin
         n_checks++; if (bus.state !== 4'd15) begin n_fail++; $display("FAIL ill_state[%0d] got %0d exp 15", i, bus.state); end
         n_checks++;
         if ({bus.mem_read, bus.mem_write, bus.reg_write, bus.ir_write, bus.pc_write, bus.pc_write_cond} !== 6'b0) begin
            n_fail++; $display("FAIL ill_enables[%0d] got %b exp 000000", i,
               {bus.mem_read, bus.mem_write, bus.reg_write, bus.ir_write, bus.pc_write, bus.pc_write_cond});
         end
         tick();
      end
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.state !== 4'd0) begin n_fail++; $display("FAIL ill_reset_state got %0d exp 0", bus.state); end
      n_checks++; if (bus.illegal_op !== 1'b0) begin n_fail++; $display("FAIL ill_reset_flag got %0b exp 0", bus.illegal_op); end
      apply_reset();
   endtask

   task automatic test_watchdog;
      bus.opcode    = 6'b000000;
      bus.mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (bus.state !== 4'd0) begin n_fail++; $display("FAIL wd_fetch[%0d] got %0d exp 0", i, bus.state); end
         tick();
      end
      n_checks++; if (bus.state !== 4'd15) begin n_fail++; $display("FAIL wd_error_state got %0d exp 15", bus.state); end
      n_checks++; if (bus.bus_error !== 1'b1) begin n_fail++; $display("FAIL wd_bus_error got %0b exp 1", bus.bus_error); end
      n_checks++; if (bus.illegal_op !== 1'b0) begin n_fail++; $display("FAIL wd_illegal got %0b exp 0", bus.illegal_op); end
      apply_reset();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      n_checks++; if (bus.state !== 4'd0) begin n_fail++; $display("FAIL wd_ready_last_fetch got %0d exp 0", bus.state); end
      bus.mem_ready = 1'b1;
      tick();
      n_checks++; if (bus.state !== 4'd1) begin n_fail++; $display("FAIL wd_ready_wins got %0d exp 1", bus.state); end
      n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL wd_ready_no_error got %0b exp 0", bus.bus_error); end
      apply_reset();
   endtask

   task automatic test_async_reset;
      bus.opcode    = 6'b101011;
      bus.mem_ready = 1'b1;
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      #1;
      n_checks++; if ({bus.state, bus.mem_write} !== 5'b01011) begin n_fail++; $display("FAIL ar_in_mem_write got %b exp 01011", {bus.state, bus.mem_write}); end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL ar_mem_write_drop got %0b exp 0", bus.mem_write); end
      n_checks++; if (bus.state !== 4'd0) begin n_fail++; $display("FAIL ar_state got %0d exp 0", bus.state); end
      n_checks++; if ({bus.mem_read, bus.i_or_d} !== 2'b10) begin n_fail++; $display("FAIL ar_fetch_outputs got %b exp 10", {bus.mem_read, bus.i_or_d}); end
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_back_to_back();
      test_illegal();
      test_watchdog();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
